// File: rtl/hazard_sequencer_pkg.sv
// Shared types and constants for the hazard sequencer slice.
package hazard_sequencer_pkg;

   localparam int REG_AW_DEF = 3;   // default register-address width
   localparam int CNT_W      = 16;  // width of the optional performance counters
   localparam int WDOG_W     = 8;   // watchdog width, enough for any timeout up to 255

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } seqState_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator: a load in EX whose destination is read by
// the instruction in ID. Register 0 is hard-wired and never creates a hazard.
module hazard_detect
   import hazard_sequencer_pkg::*;
#(
   parameter int REG_AW = REG_AW_DEF
) (
   input  logic [REG_AW-1:0] idRs,
   input  logic [REG_AW-1:0] idRt,
   input  logic              idUsesRt,
   input  logic [REG_AW-1:0] exRd,
   input  logic              exMemToReg,
   output logic              loadUse
);

   logic rsHit;
   logic rtHit;

   assign rsHit   = (exRd == idRs);
   assign rtHit   = idUsesRt && (exRd == idRt);
   assign loadUse = exMemToReg && (exRd != '0) && (rsHit || rtHit);

endmodule

// File: rtl/hazard_sequencer.sv
// Pipeline hazard sequencer: memory-wait freeze with watchdog, taken-branch
// flush and one-cycle load-use stall. Optional performance counters are
// compiled in when HAZARD_PERF_CNT_EN is defined.
module hazard_sequencer
   import hazard_sequencer_pkg::*;
#(
   parameter int REG_AW      = REG_AW_DEF,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_uses_rt,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_memtoreg,
   input  logic              ex_branch_taken,
   input  logic              mem_req,
   input  logic              mem_ready,
   output logic              pc_write,
   output logic              ifid_write,
   output logic              idex_write,
   output logic              exmem_write,
   output logic              ifid_flush,
   output logic              idex_flush,
   output logic              mem_err,
   output logic [1:0]        state_o
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  lu_stall_cnt,
   output logic [CNT_W-1:0]  br_flush_cnt,
   output logic [CNT_W-1:0]  mem_wait_cnt
`endif
);

   seqState_t         stateReg, stateNext;
   logic [WDOG_W-1:0] wdogReg, wdogNext;
   // Set after a load-use stall so that a still-visible hazard does not stall
   // a second time; only an advancing cycle consumes it.
   logic              luBlockReg, luBlockNext;
   logic              loadUse;
   logic              advance;
   logic              brFlush;
   logic              luStall;

   hazard_detect #(.REG_AW(REG_AW)) u_detect (
      .idRs       (id_rs),
      .idRt       (id_rt),
      .idUsesRt   (id_uses_rt),
      .exRd       (ex_rd),
      .exMemToReg (ex_memtoreg),
      .loadUse    (loadUse)
   );

   // Next-state, watchdog and stage-control decode; reset forces the idle outputs.
   always_comb begin
      stateNext   = RUN;
      wdogNext    = '0;
      luBlockNext = luBlockReg;
      advance     = 1'b0;
      pc_write    = 1'b1;
      ifid_write  = 1'b1;
      idex_write  = 1'b1;
      exmem_write = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      mem_err     = 1'b0;
      case (stateReg)
         RUN: begin
            if (mem_req && !mem_ready) begin
               {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
               stateNext = MEM_WAIT;
               wdogNext  = WDOG_W'(1);
            end else begin
               advance = 1'b1;
            end
         end
         MEM_WAIT: begin
            if (mem_ready) begin
               advance = 1'b1;
            end else begin
               {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
               wdogNext  = (wdogReg == '1) ? wdogReg : wdogReg + 1'b1;
               stateNext = (wdogReg == WDOG_W'(MEM_TIMEOUT)) ? ERR : MEM_WAIT;
            end
         end
         ERR: begin
            // Overwrite the faulted MEM instruction with the EX one and
            // refill EX with a bubble; front end holds.
            {pc_write, ifid_write, idex_write, exmem_write} = 4'b0001;
            idex_flush = 1'b1;
            mem_err    = 1'b1;
         end
         default: begin
            {pc_write, ifid_write, idex_write, exmem_write} = 4'b0000;
         end
      endcase

      brFlush = advance && ex_branch_taken;
      luStall = advance && !ex_branch_taken && loadUse && !luBlockReg;
      if (brFlush) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (luStall) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         idex_flush = 1'b1;
      end
      if (advance) begin
         luBlockNext = luStall;
      end

      state_o = stateReg;
      if (!rst) begin
         {pc_write, ifid_write, idex_write, exmem_write} = 4'b1111;
         ifid_flush = 1'b0;
         idex_flush = 1'b0;
         mem_err    = 1'b0;
         state_o    = RUN;
      end
   end

   // State, watchdog and stall-block registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stateReg   <= RUN;
         wdogReg    <= '0;
         luBlockReg <= 1'b0;
      end else begin
         stateReg   <= stateNext;
         wdogReg    <= wdogNext;
         luBlockReg <= luBlockNext;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] luCntReg, brCntReg, mwCntReg;

   // Saturating event counters for stalls, flushes and memory-wait cycles.
   always_ff @(posedge clk) begin
      if (!rst) begin
         luCntReg <= '0;
         brCntReg <= '0;
         mwCntReg <= '0;
      end else begin
         if (luStall && luCntReg != '1) luCntReg <= luCntReg + 1'b1;
         if (brFlush && brCntReg != '1) brCntReg <= brCntReg + 1'b1;
         if (stateReg == MEM_WAIT && mwCntReg != '1) mwCntReg <= mwCntReg + 1'b1;
      end
   end

   assign lu_stall_cnt = luCntReg;
   assign br_flush_cnt = brCntReg;
   assign mem_wait_cnt = mwCntReg;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// Self-checking bench for hazard_sequencer: directed scenarios followed by
// random stimulus checked against a behavioural model. Handles HAZARD_PERF_CNT_EN.
module tb_hazard_sequencer;

   localparam int AW  = 3;
   localparam int TMO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] id_rs, id_rt, ex_rd;
   logic          id_uses_rt, ex_memtoreg, ex_branch_taken, mem_req, mem_ready;
   logic          pc_write, ifid_write, idex_write, exmem_write;
   logic          ifid_flush, idex_flush, mem_err;
   logic [1:0]    state_o;
`ifdef HAZARD_PERF_CNT_EN
   logic [15:0]   lu_stall_cnt, br_flush_cnt, mem_wait_cnt;
`endif

   always #5 clk = ~clk;

   hazard_sequencer #(.REG_AW(AW), .MEM_TIMEOUT(TMO)) dut (
      .clk             (clk),
      .rst             (rst),
      .id_rs           (id_rs),
      .id_rt           (id_rt),
      .id_uses_rt      (id_uses_rt),
      .ex_rd           (ex_rd),
      .ex_memtoreg     (ex_memtoreg),
      .ex_branch_taken (ex_branch_taken),
      .mem_req         (mem_req),
      .mem_ready       (mem_ready),
      .pc_write        (pc_write),
      .ifid_write      (ifid_write),
      .idex_write      (idex_write),
      .exmem_write     (exmem_write),
      .ifid_flush      (ifid_flush),
      .idex_flush      (idex_flush),
      .mem_err         (mem_err),
      .state_o         (state_o)
`ifdef HAZARD_PERF_CNT_EN
      ,
      .lu_stall_cnt    (lu_stall_cnt),
      .br_flush_cnt    (br_flush_cnt),
      .mem_wait_cnt    (mem_wait_cnt)
`endif
   );

   int nChecks = 0;
   int nFails  = 0;

   // Model: mode 0 = running, 1 = waiting on memory, 2 = error cycle.
   int mMode = 0, mWait = 0, mLu = 0, mBr = 0, mMw = 0;
   bit mBlock = 0;
   int nMode, nWait, nLu, nBr, nMw;
   bit nBlock;
   logic [8:0] expVec, obsVec;

   task automatic setIdle();
      id_rs = '0; id_rt = '0; ex_rd = '0;
      id_uses_rt = 0; ex_memtoreg = 0; ex_branch_taken = 0;
      mem_req = 0; mem_ready = 0;
   endtask

   // Expected outputs for the current inputs and the model's next situation.
   task automatic modelEval();
      bit pc, fi, ix, xm, ff, fx, me, adv, hz;
      int st;
      pc = 1; fi = 1; ix = 1; xm = 1; ff = 0; fx = 0; me = 0; adv = 0;
      st = mMode;
      nMode = mMode; nWait = mWait; nBlock = mBlock;
      nLu = mLu; nBr = mBr; nMw = mMw;
      if (!rst) begin
         st = 0; nMode = 0; nWait = 0; nBlock = 0; nLu = 0; nBr = 0; nMw = 0;
      end else begin
         if (mMode == 1 && nMw < 65535) nMw++;
         if (mMode == 0) begin
            if (mem_req && !mem_ready) begin
               pc = 0; fi = 0; ix = 0; xm = 0; nMode = 1; nWait = 1;
            end else begin
               adv = 1; nWait = 0;
            end
         end else if (mMode == 1) begin
            if (mem_ready) begin
               adv = 1; nMode = 0; nWait = 0;
            end else begin
               pc = 0; fi = 0; ix = 0; xm = 0;
               nMode = (mWait == TMO) ? 2 : 1;
               nWait = (mWait < 255) ? mWait + 1 : 255;
            end
         end else begin
            pc = 0; fi = 0; ix = 0; xm = 1; fx = 1; me = 1; nMode = 0; nWait = 0;
         end
         if (adv) begin
            hz = ex_memtoreg && (ex_rd != 0) &&
                 ((ex_rd == id_rs) || (id_uses_rt && (ex_rd == id_rt)));
            if (ex_branch_taken) begin
               ff = 1; fx = 1; nBlock = 0;
               if (nBr < 65535) nBr++;
            end else if (hz && !mBlock) begin
               pc = 0; fi = 0; fx = 1; nBlock = 1;
               if (nLu < 65535) nLu++;
            end else begin
               nBlock = 0;
            end
         end
      end
      expVec = {pc, fi, ix, xm, ff, fx, me, 2'(st)};
   endtask

   // One transaction: check away from the edge, then commit the model at the edge.
   task automatic step(input string tag);
      #4;
      modelEval();
      obsVec = {pc_write, ifid_write, idex_write, exmem_write,
                ifid_flush, idex_flush, mem_err, state_o};
      nChecks++;
      assert (obsVec === expVec) else begin
         nFails++;
         $error("FAIL %s observed=%b expected=%b", tag, obsVec, expVec);
      end
`ifdef HAZARD_PERF_CNT_EN
      nChecks++;
      assert ({lu_stall_cnt, br_flush_cnt, mem_wait_cnt} === {16'(mLu), 16'(mBr), 16'(mMw)}) else begin
         nFails++;
         $error("FAIL %s_cnt observed=%0d/%0d/%0d expected=%0d/%0d/%0d", tag,
                lu_stall_cnt, br_flush_cnt, mem_wait_cnt, mLu, mBr, mMw);
      end
`endif
      $display("step %-10s rst=%0d req=%0d rdy=%0d br=%0d lu=%0d outs=%b", tag, rst,
               mem_req, mem_ready, ex_branch_taken, ex_memtoreg, obsVec);
      @(posedge clk);
      mMode = nMode; mWait = nWait; mBlock = nBlock;
      mLu = nLu; mBr = nBr; mMw = nMw;
      #1;
   endtask

   initial begin
      setIdle();
      rst = 0;
      step("reset0");
      step("reset1");
      rst = 1;
      step("idle");

      // Load-use on rs: one stall cycle, then free flow with the inputs held.
      ex_memtoreg = 1; ex_rd = 3; id_rs = 3;
      step("lu_stall");
      step("lu_after");
      setIdle();
      step("idle2");

      // Register 0 never matches.
      ex_memtoreg = 1; ex_rd = 0; id_rs = 0;
      step("reg0");

      // Taken branch wins over a simultaneous load-use hazard.
      ex_memtoreg = 1; ex_rd = 5; id_rt = 5; id_uses_rt = 1; ex_branch_taken = 1;
      step("br_lu");
      setIdle();

      // Memory wait of four cycles, resume on the ready cycle.
      mem_req = 1;
      for (int i = 0; i < 4; i++) step("memwait");
      mem_ready = 1;
      step("mem_ready");
      setIdle();
      step("idle3");

      // Watchdog expiry with ready held low.
      mem_req = 1;
      for (int i = 0; i < TMO + 2; i++) step("timeout");
      setIdle();
      step("after_err");

      // Reset during a memory wait.
      mem_req = 1;
      step("pre_rst0");
      step("pre_rst1");
      rst = 0;
      step("rst_mid");
      rst = 1; setIdle();
      step("post_rst");

      // Random traffic.
      for (int i = 0; i < 1500; i++) begin
         rst             = ($urandom_range(0, 63) != 0);
         id_rs           = AW'($urandom_range(0, 7));
         id_rt           = AW'($urandom_range(0, 7));
         ex_rd           = AW'($urandom_range(0, 7));
         id_uses_rt      = 1'($urandom_range(0, 1));
         ex_memtoreg     = 1'($urandom_range(0, 1));
         ex_branch_taken = ($urandom_range(0, 7) == 0);
         mem_req         = ($urandom_range(0, 3) == 0);
         mem_ready       = ($urandom_range(0, 2) == 0);
         step("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule

// File: doc/hazard_sequencer.md
HAZARD_SEQUENCER -- requirements
Module: hazard_sequencer

Interface
REQ-001 Parameter REG_AW, default 3, register-address width.
REQ-002 Parameter MEM_TIMEOUT, default 16, memory-wait watchdog limit in cycles (2..255).
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-low.
REQ-005 id_rs, id_rt  in  REG_AW each  source registers of the instruction in ID.
REQ-006 id_uses_rt  in  1  ID instruction reads id_rt.
REQ-007 ex_rd  in  REG_AW  destination register of the EX instruction.
REQ-008 ex_memtoreg  in  1  EX instruction is a load.
REQ-009 ex_branch_taken  in  1  branch resolved taken in EX.
REQ-010 mem_req  in  1  MEM-stage instruction accesses data memory.
REQ-011 mem_ready  in  1  data memory completes the access this cycle.
REQ-012 pc_write, ifid_write, idex_write, exmem_write  out  1 each  stage-register enables.
REQ-013 ifid_flush, idex_flush  out  1 each  insert bubble into that stage register.
REQ-014 mem_err  out  1  one-cycle watchdog-expiry pulse.
REQ-015 state_o  out  2  current FSM state.

Function
REQ-016 FSM states are RUN=0, MEM_WAIT=1, ERR=2; code 3 is illegal and returns to RUN next cycle.
REQ-017 Load-use hazard: ex_memtoreg & (ex_rd==id_rs | (id_uses_rt & ex_rd==id_rt)); a register address of 0 never matches.
REQ-018 In RUN with no condition: all enables 1, all flushes 0.
REQ-019 In RUN with mem_req & !mem_ready: all four enables 0, flushes 0, next state MEM_WAIT, watchdog loads 1.
REQ-020 In RUN with mem_req & mem_ready, or !mem_req: pipeline advances this cycle.
REQ-021 In RUN with an advancing pipeline and ex_branch_taken: ifid_flush=1 and idex_flush=1.
REQ-022 In RUN with an advancing pipeline, a load-use hazard and no branch: pc_write=0, ifid_write=0, idex_flush=1, for exactly one cycle.
REQ-023 Priority: memory wait > taken branch > load-use.
REQ-024 In MEM_WAIT: all enables 0, flushes 0, watchdog increments each cycle.
REQ-025 In MEM_WAIT with mem_ready: leave next cycle to RUN; the ready cycle itself advances the pipeline under REQ-020 to REQ-023.
REQ-026 In MEM_WAIT when the watchdog equals MEM_TIMEOUT with !mem_ready: next state ERR.
REQ-027 ERR lasts one cycle with mem_err=1, exmem_write=1, the MEM instruction squashed via the stage's bubble, and the other enables 0; ERR then returns to RUN.
REQ-028 Branch or load-use conditions present during MEM_WAIT are held by the frozen stages and evaluated on resumption; none are lost.
REQ-029 The watchdog saturates and never wraps.

Reset
REQ-030 While rst=0: state RUN, watchdog 0, mem_err 0, all enables 1, all flushes 0.
REQ-031 Reset asserted mid-MEM_WAIT or mid-ERR aborts to RUN on the next edge with no mem_err pulse.

Configuration
REQ-032 Macro HAZARD_PERF_CNT_EN, when defined, adds outputs lu_stall_cnt[15:0], br_flush_cnt[15:0] and mem_wait_cnt[15:0].
REQ-033 With the macro, each counter increments once per REQ-022 stall, REQ-021 flush or MEM_WAIT cycle respectively, saturates at 16'hFFFF, and resets to 0.
REQ-034 Without the macro, these ports and their logic are absent; all other behaviour is identical.

Structure
REQ-035 A shared package holds the state enum (RUN, MEM_WAIT, ERR), the REG_AW default and the counter width.
REQ-036 One sub-module, hazard_detect, is the combinational load-use comparator of REQ-017.
REQ-037 The FSM, watchdog and optional counters stay in hazard_sequencer.

Verification
REQ-038 Load-use: ex_memtoreg=1, ex_rd=3, id_rs=3 -> one cycle of pc_write=0, ifid_write=0, idex_flush=1, then all enables 1.
REQ-039 Register 0: ex_memtoreg=1, ex_rd=0, id_rs=0 -> no stall.
REQ-040 Branch with load-use: ex_branch_taken=1 and a load-use hazard in the same cycle -> ifid_flush=1, idex_flush=1, pc_write=1, no stall.
REQ-041 Memory wait: mem_req=1 with mem_ready low for 4 cycles -> enables 0 for 4 cycles, state_o=1, resume on the ready cycle, mem_err never pulses.
REQ-042 Timeout: MEM_TIMEOUT=4, mem_ready held low -> state_o=2 with mem_err=1 for one cycle, then RUN.
REQ-043 Reset mid-wait: rst=0 during MEM_WAIT -> next edge state_o=0, all enables 1, mem_err=0; with HAZARD_PERF_CNT_EN defined, all counters read 0.
